// File: rtl/pac_pkg.sv
// Shared definitions for the Pacman movement controller and its helpers:
// direction codes, tile size, coordinate widths and the FSM state enum.
package pac_pkg;

    localparam int TILE = 16;
    localparam int X_W  = 10;
    localparam int Y_W  = 9;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRY_PEND,
        ST_WAIT_PEND,
        ST_TRY_CUR,
        ST_WAIT_CUR
    } state_t;

endpackage

// File: rtl/pac_move_ctrl_if.sv
// Collision-query channel: valid/ready query (q_*) from the mover to the
// wall checker and a one-cycle response pulse (r_valid, r_free) back.
// Ports: master = query initiator, slave = wall/collision checker.
interface pac_move_ctrl_if;

    logic                    q_valid;
    logic [pac_pkg::X_W-1:0] q_x;
    logic [pac_pkg::Y_W-1:0] q_y;
    logic                    q_ready;
    logic                    r_valid;
    logic                    r_free;

    modport master (
        output q_valid, q_x, q_y,
        input  q_ready, r_valid, r_free
    );

    modport slave (
        input  q_valid, q_x, q_y,
        output q_ready, r_valid, r_free
    );

endinterface

// File: rtl/pac_next_tile.sv
// Combinational next-tile candidate: one TILE step from (x, y) along dir,
// plus an out-of-field flag. Ports: x, y, dir in; nx, ny, oob out.
// PAC_TUNNEL_WRAP_EN: horizontal exits wrap to the opposite edge instead
// of being flagged out-of-field.
module pac_next_tile
    import pac_pkg::*;
#(
    parameter logic [X_W-1:0] X_MAX = 10'd624,
    parameter logic [Y_W-1:0] Y_MAX = 9'd464
) (
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic [1:0]     dir,
    output logic [X_W-1:0] nx,
    output logic [Y_W-1:0] ny,
    output logic           oob
);

    localparam logic [X_W-1:0] TX = X_W'(TILE);
    localparam logic [Y_W-1:0] TY = Y_W'(TILE);

    // One extra bit so x+16 / y+16 cannot wrap before the bound check.
    logic [X_W:0] x_inc;
    logic [Y_W:0] y_inc;

    assign x_inc = {1'b0, x} + {1'b0, TX};
    assign y_inc = {1'b0, y} + {1'b0, TY};

    always_comb begin
        nx  = x;
        ny  = y;
        oob = 1'b0;
        unique case (dir)
            DIR_UP: begin
                if (y < TY) oob = 1'b1;
                else        ny  = y - TY;
            end
            DIR_DOWN: begin
                if (y_inc > {1'b0, Y_MAX}) oob = 1'b1;
                else                       ny  = y_inc[Y_W-1:0];
            end
            DIR_LEFT: begin
                if (x < TX) begin
`ifdef PAC_TUNNEL_WRAP_EN
                    nx = X_MAX;
`else
                    oob = 1'b1;
`endif
                end else begin
                    nx = x - TX;
                end
            end
            DIR_RIGHT: begin
                if (x_inc > {1'b0, X_MAX}) begin
`ifdef PAC_TUNNEL_WRAP_EN
                    nx = '0;
`else
                    oob = 1'b1;
`endif
                end else begin
                    nx = x_inc[X_W-1:0];
                end
            end
        endcase
    end

endmodule

// File: rtl/pac_move_ctrl.sv
// Pacman movement controller: per tick, tries the pending heading then the
// current one via the collision-query channel and commits the first free move.
// Ports: clk, rst, tick, dir_req, dir_req_valid, bus (query master),
// PacX, PacY, cur_dir, moving, tick_miss. Option: PAC_TUNNEL_WRAP_EN.
module pac_move_ctrl
    import pac_pkg::*;
#(
    parameter logic [X_W-1:0] START_X = 10'd304,
    parameter logic [Y_W-1:0] START_Y = 9'd272,
    parameter logic [X_W-1:0] X_MAX   = 10'd624,
    parameter logic [Y_W-1:0] Y_MAX   = 9'd464,
    parameter int             TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [1:0]        dir_req,
    input  logic              dir_req_valid,
    pac_move_ctrl_if.master   bus,
    output logic [X_W-1:0]    PacX,
    output logic [Y_W-1:0]    PacY,
    output logic [1:0]        cur_dir,
    output logic              moving,
    output logic              tick_miss
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t state, state_n;

    logic [1:0]     pend_dir;
    logic [X_W-1:0] cand_x;
    logic [Y_W-1:0] cand_y;
    logic [1:0]     cand_dir;
    logic           cand_oob;
    logic [CNT_W-1:0] cnt;

    logic [1:0]     tile_dir;
    logic [X_W-1:0] nx;
    logic [Y_W-1:0] ny;
    logic           n_oob;

    logic ld_cand;
    logic commit;
    logic block;
    logic cnt_clr;
    logic cnt_inc;
    logic q_valid_c;
    logic last;

    pac_next_tile #(
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_next (
        .x   (PacX),
        .y   (PacY),
        .dir (tile_dir),
        .nx  (nx),
        .ny  (ny),
        .oob (n_oob)
    );

    assign bus.q_valid = q_valid_c;
    assign bus.q_x     = cand_x;
    assign bus.q_y     = cand_y;

    assign last = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        tile_dir  = cur_dir;
        ld_cand   = 1'b0;
        commit    = 1'b0;
        block     = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        q_valid_c = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (tick) begin
                    ld_cand = 1'b1;
                    if (pend_dir != cur_dir) begin
                        tile_dir = pend_dir;
                        state_n  = ST_TRY_PEND;
                    end else begin
                        state_n  = ST_TRY_CUR;
                    end
                end
            end
            ST_TRY_PEND: begin
                // Out-of-field candidate: skip the query, fall to current.
                if (cand_oob) begin
                    ld_cand = 1'b1;
                    state_n = ST_TRY_CUR;
                end else begin
                    q_valid_c = 1'b1;
                    if (bus.q_ready) begin
                        cnt_clr = 1'b1;
                        state_n = ST_WAIT_PEND;
                    end
                end
            end
            ST_WAIT_PEND: begin
                if (bus.r_valid && bus.r_free) begin
                    commit  = 1'b1;
                    state_n = ST_IDLE;
                end else if (bus.r_valid || last) begin
                    ld_cand = 1'b1;
                    state_n = ST_TRY_CUR;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_TRY_CUR: begin
                if (cand_oob) begin
                    block   = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    q_valid_c = 1'b1;
                    if (bus.q_ready) begin
                        cnt_clr = 1'b1;
                        state_n = ST_WAIT_CUR;
                    end
                end
            end
            ST_WAIT_CUR: begin
                if (bus.r_valid && bus.r_free) begin
                    commit  = 1'b1;
                    state_n = ST_IDLE;
                end else if (bus.r_valid || last) begin
                    block   = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_dir  <= DIR_LEFT;
            cur_dir   <= DIR_LEFT;
            PacX      <= START_X;
            PacY      <= START_Y;
            moving    <= 1'b0;
            tick_miss <= 1'b0;
            cand_x    <= '0;
            cand_y    <= '0;
            cand_dir  <= DIR_LEFT;
            cand_oob  <= 1'b0;
            cnt       <= '0;
        end else begin
            if (dir_req_valid) pend_dir <= dir_req;
            tick_miss <= tick && (state != ST_IDLE);
            // Candidate is frozen here so q_x/q_y hold while q_valid waits.
            if (ld_cand) begin
                cand_x   <= nx;
                cand_y   <= ny;
                cand_dir <= tile_dir;
                cand_oob <= n_oob;
            end
            if (commit) begin
                PacX    <= cand_x;
                PacY    <= cand_y;
                cur_dir <= cand_dir;
                moving  <= 1'b1;
            end else if (block) begin
                moving  <= 1'b0;
            end
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pac_move_ctrl.sv
// Directed testbench for pac_move_ctrl: the bench plays the wall checker
// and compares outputs against hand-computed positions and timing.
module tb_pac_move_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [1:0] dir_req;
    logic       dir_req_valid;
    logic [9:0] PacX;
    logic [8:0] PacY;
    logic [1:0] cur_dir;
    logic       moving;
    logic       tick_miss;

    int compared   = 0;
    int mismatched = 0;
    int hs         = 0;
    int hs0;

    pac_move_ctrl_if qif ();

    pac_move_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .dir_req       (dir_req),
        .dir_req_valid (dir_req_valid),
        .bus           (qif),
        .PacX          (PacX),
        .PacY          (PacY),
        .cur_dir       (cur_dir),
        .moving        (moving),
        .tick_miss     (tick_miss)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (qif.q_valid && qif.q_ready) hs++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic move_free();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        qif.r_valid = 1'b1;
        qif.r_free  = 1'b1;
        step();
        qif.r_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        tick          = 1'b0;
        dir_req       = 2'b10;
        dir_req_valid = 1'b0;
        qif.q_ready   = 1'b1;
        qif.r_valid   = 1'b0;
        qif.r_free    = 1'b0;
        step();
        step();
        rst = 1'b0;

        chk("rst_x", PacX, 304);
        chk("rst_y", PacY, 272);
        chk("rst_dir", cur_dir, 2);
        chk("rst_mov", moving, 0);
        chk("rst_qv", qif.q_valid, 0);
        chk("rst_qx", qif.q_x, 0);
        chk("rst_tm", tick_miss, 0);

        // Best case: commit 3 cycles after tick.
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("t1_qv", qif.q_valid, 1);
        chk("t1_qx", qif.q_x, 288);
        chk("t1_qy", qif.q_y, 272);
        step();
        chk("t1_qv_drop", qif.q_valid, 0);
        qif.r_valid = 1'b1;
        qif.r_free  = 1'b1;
        chk("t1_x_early", PacX, 304);
        step();
        qif.r_valid = 1'b0;
        chk("t1_x", PacX, 288);
        chk("t1_y", PacY, 272);
        chk("t1_mov", moving, 1);

        // Pending up blocked, current left free.
        rst = 1'b1;
        step();
        rst = 1'b0;
        dir_req       = 2'b00;
        dir_req_valid = 1'b1;
        step();
        dir_req_valid = 1'b0;
        hs0  = hs;
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("t2_pqv", qif.q_valid, 1);
        chk("t2_pqx", qif.q_x, 304);
        chk("t2_pqy", qif.q_y, 256);
        step();
        qif.r_valid = 1'b1;
        qif.r_free  = 1'b0;
        step();
        qif.r_valid = 1'b0;
        chk("t2_cqv", qif.q_valid, 1);
        chk("t2_cqx", qif.q_x, 288);
        chk("t2_cqy", qif.q_y, 272);
        step();
        qif.r_valid = 1'b1;
        qif.r_free  = 1'b1;
        step();
        qif.r_valid = 1'b0;
        chk("t2_x", PacX, 288);
        chk("t2_y", PacY, 272);
        chk("t2_dir", cur_dir, 2);
        chk("t2_mov", moving, 1);
        chk("t2_nq", hs - hs0, 2);

        // q_ready low for 5 cycles; candidate must hold.
        dir_req       = 2'b10;
        dir_req_valid = 1'b1;
        step();
        dir_req_valid = 1'b0;
        qif.q_ready   = 1'b0;
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_qv", qif.q_valid, 1);
            chk("t3_qx", qif.q_x, 272);
            chk("t3_qy", qif.q_y, 272);
            dir_req       = 2'b11;
            dir_req_valid = (i == 1);
            step();
        end
        dir_req_valid = 1'b0;
        chk("t3_qv6", qif.q_valid, 1);
        chk("t3_qx6", qif.q_x, 272);
        qif.q_ready = 1'b1;
        step();
        chk("t3_qv_drop", qif.q_valid, 0);
        qif.r_valid = 1'b1;
        qif.r_free  = 1'b1;
        step();
        qif.r_valid = 1'b0;
        chk("t3_x", PacX, 272);
        chk("t3_dir", cur_dir, 2);

        // Both attempts time out; tick_miss during WAIT_PEND.
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("t4_pqx", qif.q_x, 288);
        chk("t4_pqy", qif.q_y, 272);
        step();
        for (int i = 0; i < 7; i++) begin
            tick = (i == 2);
            step();
            chk("t4_wp_qv", qif.q_valid, 0);
            if (i == 2) chk("t4_tm_hi", tick_miss, 1);
            if (i == 3) chk("t4_tm_lo", tick_miss, 0);
        end
        tick = 1'b0;
        step();
        chk("t4_cqv", qif.q_valid, 1);
        chk("t4_cqx", qif.q_x, 256);
        step();
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t4_wc_mov", moving, 1);
        end
        step();
        chk("t4_mov", moving, 0);
        chk("t4_x", PacX, 272);
        chk("t4_dir", cur_dir, 2);

        // r_valid on the last timeout cycle wins.
        dir_req       = 2'b10;
        dir_req_valid = 1'b1;
        step();
        dir_req_valid = 1'b0;
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("t5_qx", qif.q_x, 256);
        step();
        for (int i = 0; i < 7; i++) step();
        qif.r_valid = 1'b1;
        qif.r_free  = 1'b1;
        step();
        qif.r_valid = 1'b0;
        chk("t5_x", PacX, 256);
        chk("t5_mov", moving, 1);

        // Reset in WAIT_CUR; late response ignored.
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("t6_qx", qif.q_x, 240);
        step();
        rst = 1'b1;
        step();
        chk("t6_qv", qif.q_valid, 0);
        chk("t6_x", PacX, 304);
        chk("t6_mov", moving, 0);
        rst = 1'b0;
        qif.r_valid = 1'b1;
        qif.r_free  = 1'b1;
        step();
        qif.r_valid = 1'b0;
        chk("t6_x_late", PacX, 304);
        chk("t6_qv_late", qif.q_valid, 0);

        // Walk to the left edge, then try to go further.
        for (int i = 0; i < 19; i++) move_free();
        chk("t7_x0", PacX, 0);
        chk("t7_y", PacY, 272);
        hs0  = hs;
        tick = 1'b1;
        step();
        tick = 1'b0;
`ifdef PAC_TUNNEL_WRAP_EN
        chk("t7_qv", qif.q_valid, 1);
        chk("t7_qx", qif.q_x, 624);
        step();
        qif.r_valid = 1'b1;
        qif.r_free  = 1'b1;
        step();
        qif.r_valid = 1'b0;
        chk("t7_x", PacX, 624);
        chk("t7_mov", moving, 1);
`else
        chk("t7_qv", qif.q_valid, 0);
        step();
        chk("t7_mov", moving, 0);
        chk("t7_x", PacX, 0);
        chk("t7_nq", hs - hs0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pac_move_ctrl.md
# pac_move_ctrl

Pacman movement controller: on each movement tick it proposes the next tile position to the wall/collision checker over a valid/ready query channel, waits for the free/blocked response, and commits the position and heading. It sits between the keyboard direction decoder and the position consumers (renderer, ghost AI, pellet logic), acting as the initiator of the collision-query protocol.

## Interface
- START_X, 10'd304: PacX after reset (tile-aligned, multiple of 16)
- START_Y, 9'd272: PacY after reset
- X_MAX, 10'd624: largest legal tile origin in x
- Y_MAX, 9'd464: largest legal tile origin in y
- TIMEOUT, 8: cycles to wait for a response before treating the move as blocked
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick  in  1  one-cycle movement strobe
- dir_req  in  2  requested heading: 00 up, 01 down, 10 left, 11 right
- dir_req_valid  in  1  dir_req is a new request; latched into the pending register
- q_valid  out  1  query valid
- q_x  out  10  candidate tile x
- q_y  out  9  candidate tile y
- q_ready  in  1  checker accepts query
- r_valid  in  1  response valid, one-cycle pulse
- r_free  in  1  with r_valid: 1 = no wall, 0 = wall
- PacX  out  10  committed x
- PacY  out  9  committed y
- cur_dir  out  2  committed heading
- moving  out  1  last tick produced a move
- tick_miss  out  1  one-cycle pulse: tick arrived while busy

## Operation
- Reset values: PacX=START_X, PacY=START_Y, cur_dir=2'b10, pend_dir=2'b10, moving=0, q_valid=0, q_x=0, q_y=0, tick_miss=0, state IDLE, timeout counter 0.
- pend_dir loads dir_req whenever dir_req_valid=1, in any state.
- Candidate for heading d: up y−16, down y+16, left x−16, right x+16; x in 10 bits, y in 9 bits.
- Out-of-field candidate (left with PacX<16, right with PacX+16>X_MAX, up with PacY<16, down with PacY+16>Y_MAX): blocked immediately, no query issued.
- States: IDLE → TRY_PEND → WAIT_PEND → TRY_CUR → WAIT_CUR → IDLE.
  - IDLE, tick=1: if pend_dir≠cur_dir go TRY_PEND, else TRY_CUR.
  - TRY_*: q_valid=1 with candidate; on q_valid&q_ready go WAIT_*.
  - WAIT_PEND: r_valid&r_free → commit pend_dir move (cur_dir←pend_dir, position←candidate, moving←1), IDLE. Blocked or timeout → TRY_CUR.
  - WAIT_CUR: free → commit cur_dir move, IDLE. Blocked or timeout → moving←0, position unchanged, IDLE.
- Candidate coordinates are captured in TRY_*; they remain stable while q_valid=1 even if dir_req changes.
- r_valid in IDLE/TRY_* is ignored.
- tick in any state other than IDLE: tick_miss pulses, tick is dropped.

## Timing
- tick in IDLE → q_valid=1 the next cycle.
- q_valid holds until the handshake; it drops on the cycle after acceptance.
- Commit occurs on the cycle after r_valid; PacX/PacY/cur_dir/moving update together.
- Timeout: counter starts at 0 on entry to WAIT_*; after TIMEOUT cycles without r_valid, the response is treated as blocked. r_valid and the last timeout cycle together → r_valid wins.
- Best case, pend succeeds with q_ready already high: commit 3 cycles after tick.
- rst mid-transaction: next cycle q_valid=0; all reset values apply; late r_valid is ignored.

## Configuration
- PAC_TUNNEL_WRAP_EN defined: horizontal out-of-field candidates wrap (left from 0 → X_MAX, right from X_MAX → 0) and are queried normally. Vertical behaviour is unchanged.
- Undefined: every out-of-field candidate is blocked without a query.

## Structure
- Shared package pac_pkg: direction encoding constants (DIR_UP/DOWN/LEFT/RIGHT), TILE=16, coordinate widths, and the FSM state enum.
- One sub-module, pac_next_tile: a combinational candidate and out-of-field/wrap computation from (PacX, PacY, dir). It is reused by the ghost controller.

## Test plan
- Reset at (304,272); pend=left; tick; checker has q_ready=1 and returns r_free=1 one cycle later → PacX=288, PacY=272, moving=1, commit 3 cycles after tick.
- cur=left, pend=up; tick; up query (304,256) returns blocked; left query (288,272) returns free → cur_dir=10, PacX=288, two queries issued.
- PacX=0, heading left, macro off → no q_valid, moving=0. With macro on → query x=624; free → PacX=624.
- q_ready held low 5 cycles → q_x/q_y are stable throughout; the handshake occurs on cycle 6.
- No r_valid after acceptance → after 8 cycles the FSM falls through to the next state; with both attempts timing out, moving=0 and position unchanged.
- tick during WAIT_PEND → tick_miss pulses once; assert rst during WAIT_CUR → q_valid=0 and PacX=304 the next cycle.
